uart_cfg_frame_parser: RTL



---
 rtl/uart_cfg_pkg.sv | 18 +
 rtl/uart_cfg_regbank.sv | 49 ++++
 rtl/uart_cfg_frame_parser.sv | 97 +++++++++
 3 files changed

// File: rtl/uart_cfg_pkg.sv
// uart_cfg_pkg: shared parser states, error codes and stop-selector decode
package uart_cfg_pkg;
  typedef enum logic [2:0] {ST_H0, ST_H1, ST_H2, ST_CH, ST_MODE, ST_INTV, ST_BAUD, ST_CSUM} st_t;
  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_CSUM = 3'd1;
  localparam logic [2:0] ERR_CH = 3'd2;
  localparam logic [2:0] ERR_MODE = 3'd3;
  localparam logic [2:0] ERR_BAUD = 3'd4;
  localparam logic [2:0] ERR_TMO = 3'd5;
  // bytes preceding the checksum byte
  localparam int FRAME_LEN = 13;
  // {valid, stop code}: selector 1..4 maps to 11,10,01,00
  function automatic logic [2:0] stop_dec(input logic [2:0] s);
    logic [2:0] d;
    d = 3'd4 - s;
    return {s != 3'd0 && s <= 3'd4, d[1:0]};
  endfunction
endpackage

// File: rtl/uart_cfg_regbank.sv
// uart_cfg_regbank: per-channel UART settings with committed-write strobe
module uart_cfg_regbank #(
  parameter int NUM_CH = 4,
  parameter int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1,
  parameter logic [31:0] DEF_BAUD = 32'd115200,
  parameter logic [31:0] DEF_INTERVAL = 32'd0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [CW-1:0]          ch,
  input  logic                   par,
  input  logic [1:0]             stp,
  input  logic [31:0]            intv,
  input  logic [31:0]            bd,
  output logic [NUM_CH-1:0]      parity,
  output logic [2*NUM_CH-1:0]    stopbit,
  output logic [32*NUM_CH-1:0]   interval,
  output logic [32*NUM_CH-1:0]   baud,
  output logic [NUM_CH-1:0]      cfg_update
);
  logic [1:0] stp_r [NUM_CH];
  logic [31:0] intv_r [NUM_CH];
  logic [31:0] bd_r [NUM_CH];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      parity <= '0;
      cfg_update <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        stp_r[i] <= 2'b11;
        intv_r[i] <= DEF_INTERVAL;
        bd_r[i] <= DEF_BAUD;
      end
    end else begin
      cfg_update <= '0;
      if (we) begin
        parity[ch] <= par;
        stp_r[ch] <= stp;
        intv_r[ch] <= intv;
        bd_r[ch] <= bd;
        cfg_update[ch] <= 1'b1;
      end
    end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_flat
    assign stopbit[2*c+:2] = stp_r[c];
    assign interval[32*c+:32] = intv_r[c];
    assign baud[32*c+:32] = bd_r[c];
  end
endmodule

// File: rtl/uart_cfg_frame_parser.sv
// uart_cfg_frame_parser: framed config byte parser with checksum, range checks and timeout
module uart_cfg_frame_parser
  import uart_cfg_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter logic [23:0] HDR = 24'hEEDDCC,
  parameter logic [31:0] DEF_BAUD = 32'd115200,
  parameter logic [31:0] DEF_INTERVAL = 32'd0,
  parameter logic [31:0] BAUD_MIN = 32'd1200,
  parameter logic [31:0] BAUD_MAX = 32'd3000000,
  parameter logic [31:0] TIMEOUT_CYC = 32'd1000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wen,
  input  logic [7:0]             din,
  output logic [NUM_CH-1:0]      parity,
  output logic [2*NUM_CH-1:0]    stopbit,
  output logic [32*NUM_CH-1:0]   interval,
  output logic [32*NUM_CH-1:0]   baud,
  output logic [NUM_CH-1:0]      cfg_update,
  output logic                   err_valid,
  output logic [2:0]             err_code,
  output logic                   busy
);
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  st_t state, nxt, hdr_fb;
  logic [31:0] cnt, sh_int, sh_baud;
  logic [7:0] sh_ch, xr;
  logic [2:0] sh_sel, sd, ecode;
  logic [1:0] bc;
  logic sh_par, fin, commit, fin_err, tmo;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_H0;
    else state <= nxt;
  always_comb begin
    nxt = state;
    hdr_fb = din == HDR[23:16] ? ST_H1 : ST_H0;
    if (tmo) nxt = ST_H0;
    else if (wen)
      case (state)
        ST_H0:   nxt = hdr_fb;
        ST_H1:   nxt = din == HDR[15:8] ? ST_H2 : hdr_fb;
        ST_H2:   nxt = din == HDR[7:0] ? ST_CH : hdr_fb;
        ST_CH:   nxt = ST_MODE;
        ST_MODE: nxt = ST_INTV;
        ST_INTV: nxt = bc == 2'd3 ? ST_BAUD : ST_INTV;
        ST_BAUD: nxt = bc == 2'd3 ? ST_CSUM : ST_BAUD;
        default: nxt = ST_H0;
      endcase
  end
  always_comb begin
    sd = stop_dec(sh_sel);
    ecode = din != xr ? ERR_CSUM :
            {24'd0, sh_ch} >= 32'(NUM_CH) ? ERR_CH :
            !sd[2] ? ERR_MODE :
            sh_baud < BAUD_MIN || sh_baud > BAUD_MAX ? ERR_BAUD : ERR_NONE;
    fin = wen && state == ST_CSUM;
    commit = fin && ecode == ERR_NONE;
    fin_err = fin && ecode != ERR_NONE;
    tmo = TIMEOUT_CYC != 32'd0 && state != ST_H0 && !wen && cnt >= TIMEOUT_CYC - 32'd1;
  end
  // cnt holds the idle cycles since the last byte; it saturates rather than wraps
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      bc <= '0;
      xr <= '0;
      sh_ch <= '0;
      sh_par <= 1'b0;
      sh_sel <= '0;
      sh_int <= '0;
      sh_baud <= '0;
      err_valid <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      err_valid <= fin_err || tmo;
      if (fin_err || tmo) err_code <= tmo ? ERR_TMO : ecode;
      if (wen) begin
        cnt <= '0;
        xr <= state == ST_CH ? din : xr ^ din;
        bc <= state == ST_INTV || state == ST_BAUD ? bc + 2'd1 : 2'd0;
        if (state == ST_CH) sh_ch <= din;
        if (state == ST_MODE) {sh_par, sh_sel} <= {din[4], din[2:0]};
        if (state == ST_INTV) sh_int <= {sh_int[23:0], din};
        if (state == ST_BAUD) sh_baud <= {sh_baud[23:0], din};
      end else if (state != ST_H0 && cnt != '1) cnt <= cnt + 32'd1;
    end
  assign busy = state != ST_H0;
  uart_cfg_regbank #(
    .NUM_CH(NUM_CH), .CW(CW), .DEF_BAUD(DEF_BAUD), .DEF_INTERVAL(DEF_INTERVAL)
  ) u_regbank (
    .clk(clk), .rst(rst), .we(commit), .ch(sh_ch[CW-1:0]), .par(sh_par), .stp(sd[1:0]),
    .intv(sh_int), .bd(sh_baud), .parity(parity), .stopbit(stopbit), .interval(interval),
    .baud(baud), .cfg_update(cfg_update)
  );
endmodule
